keycode_event_tracker: RTL
==========================

KEYCODE_EVENT_TRACKER -- requirements
Module: keycode_event_tracker

Interface
REQ-001 Parameter NSLOT, default 6: number of keycode slots per keyboard report.
REQ-002 Parameter NKEY, default 10: number of tracked keys.
REQ-003 Parameter KEYMAP, default {8'h29,8'h28,8'h2C,8'h52,8'h4F,8'h50,8'h09,8'h1A,8'h07,8'h04}: NKEY*8 bits; key i code is KEYMAP[8i+7:8i].
REQ-004 Parameter REPEAT_DELAY, default 25_000_000: cycles from press to first repeat; legal range 1..2^CW-1.
REQ-005 Parameter REPEAT_PERIOD, default 5_000_000: cycles between subsequent repeats; legal range 1..2^CW-1.
REQ-006 Parameter CW, default 25: repeat counter width.
REQ-007 Clk  input  1  sole clock; all state updates on rising edge.
REQ-008 Reset_n  input  1  synchronous, active-low reset.
REQ-009 keycode  input  NSLOT*8  report slots; slot s is keycode[8s+7:8s].
REQ-010 kc_valid  input  1  one-cycle strobe: keycode holds a new report.
REQ-011 repeat_en  input  1  enables auto-repeat generation.
REQ-012 key_held  output  NKEY  registered level: key present in last accepted report.
REQ-013 key_press  output  NKEY  one-cycle pulse on press.
REQ-014 key_release  output  NKEY  one-cycle pulse on release.
REQ-015 key_repeat  output  NKEY  one-cycle auto-repeat pulse.
REQ-016 any_held  output  1  OR of key_held.
REQ-017 rollover_err  output  1  one-cycle pulse when a report is rejected.

Function
REQ-018 Key i SHALL be detected present when any slot equals its KEYMAP code; a code in several slots counts once.
REQ-019 Code 8'h00 in KEYMAP SHALL never match; slots equal to 8'h00 are empty.
REQ-020 Reports SHALL be sampled only in cycles with kc_valid=1; outside them all held state SHALL be unchanged.
REQ-021 A report with any slot equal to 8'h01 (rollover) SHALL be rejected: key_held, key state and counters unchanged, rollover_err=1 next cycle, no press/release pulses.
REQ-022 Accepted report at cycle t SHALL update key_held at t+1; key_press[i]=1 at t+1 iff absent->present; key_release[i]=1 at t+1 iff present->absent.
REQ-023 Each key SHALL run an FSM IDLE -> DELAY -> REPEAT: press enters DELAY with counter=0; release from any state returns to IDLE with counter=0.
REQ-024 In DELAY, counter SHALL increment each cycle; reaching REPEAT_DELAY-1 SHALL pulse key_repeat next cycle, go to REPEAT, clear counter.
REQ-025 In REPEAT, counter reaching REPEAT_PERIOD-1 SHALL pulse key_repeat next cycle and clear counter; first repeat exactly REPEAT_DELAY cycles after key_press, then every REPEAT_PERIOD cycles.
REQ-026 Counters SHALL saturate-free wrap only via the clear in REQ-024/025; no value beyond the parameter is reachable.
REQ-027 repeat_en=0 SHALL suppress key_repeat and hold counters at 0 in DELAY; asserting repeat_en restarts the delay from 0.
REQ-028 Release and a due repeat in the same cycle: release SHALL win, key_repeat=0.
REQ-029 Press pulse and repeat pulse SHALL never coincide for a key.
REQ-030 Re-press while held (present in consecutive reports) SHALL not generate key_press nor reset the counter.
REQ-031 Keys SHALL be independent; simultaneous presses of several keys each produce their own pulses.
REQ-032 Pulse outputs SHALL be registered and high for exactly one cycle.

Reset
REQ-033 Reset_n=0 at a clock edge SHALL clear key_held, key_press, key_release, key_repeat, any_held, rollover_err to 0, all FSMs to IDLE, all counters to 0.
REQ-034 Reset mid-hold SHALL produce no release pulse; a key still present in the first report after reset SHALL produce key_press.
REQ-035 kc_valid during reset SHALL be ignored.

Verification (REPEAT_DELAY=8, REPEAT_PERIOD=3 for bench)
REQ-036 Report {04,00,00,00,00,00} at t -> key_held=10'h001, key_press=10'h001 at t+1 only; key_repeat[0] at t+9, t+12, t+15.
REQ-037 Then report all 00 at t+11 -> key_release[0]=1 at t+12, key_repeat[0]=0 at t+12, key_held=0.
REQ-038 Report {04,07,04,00,00,00} -> key_press=10'h003 one cycle; duplicate 04 single event.
REQ-039 Held {50}, then report {01,01,01,01,01,01} -> rollover_err one cycle, key_held unchanged, no release.
REQ-040 Held {2C} with repeat_en=0 for 20 cycles -> no key_repeat; raise repeat_en -> first repeat 8 cycles later.
REQ-041 Reset_n=0 one cycle while {28} held, then report {28} -> all outputs 0 during reset, key_press[8]=1 after report, no key_release.

Source files
------------

// File: rtl/keycode_event_tracker.sv
// keycode_event_tracker: turns keyboard reports into per-key held levels and press/release/auto-repeat pulses.
module keycode_event_tracker #(
  parameter int NSLOT = 6,
  parameter int NKEY = 10,
  parameter logic [NKEY*8-1:0] KEYMAP = {8'h29, 8'h28, 8'h2C, 8'h52, 8'h4F, 8'h50, 8'h09, 8'h1A, 8'h07, 8'h04},
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CW = 25
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NSLOT*8-1:0] keycode,
  input  logic               kc_valid,
  input  logic               repeat_en,
  output logic [NKEY-1:0]    key_held,
  output logic [NKEY-1:0]    key_press,
  output logic [NKEY-1:0]    key_release,
  output logic [NKEY-1:0]    key_repeat,
  output logic               any_held,
  output logic               rollover_err
);
  typedef enum logic [1:0] {IDLE, DELAY, RPT} st_t;
  localparam logic [CW-1:0] L_DLY = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] L_PER = CW'(REPEAT_PERIOD - 1);
  logic [NKEY-1:0] r_held, r_press, r_rel, r_rep;
  logic [NKEY-1:0] w_pres, w_held_n, w_press, w_rel, w_rep;
  logic            r_roll, w_roll, w_acc;
  st_t             r_st [NKEY];
  st_t             w_st [NKEY];
  logic [CW-1:0]   r_cnt [NKEY];
  logic [CW-1:0]   w_cnt [NKEY];
  // a 00 map entry never matches, so empty slots cannot press anything
  always_comb begin
    w_pres = '0;
    w_roll = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      w_roll = w_roll | (keycode[8*s +: 8] == 8'h01);
      for (int k = 0; k < NKEY; k++)
        if (KEYMAP[8*k +: 8] != 8'h00 && keycode[8*s +: 8] == KEYMAP[8*k +: 8]) w_pres[k] = 1'b1;
    end
  end
  assign w_acc    = kc_valid & ~w_roll;
  assign w_held_n = w_acc ? w_pres : r_held;
  assign w_press  = w_held_n & ~r_held;
  assign w_rel    = r_held & ~w_held_n;
  // release outranks everything, so a due repeat is dropped in the release cycle
  always_comb begin
    w_st  = r_st;
    w_cnt = r_cnt;
    w_rep = '0;
    for (int k = 0; k < NKEY; k++) begin
      if (w_rel[k]) begin
        w_st[k]  = IDLE;
        w_cnt[k] = '0;
      end else if (w_press[k] || (r_st[k] != IDLE && !repeat_en)) begin
        w_st[k]  = DELAY;
        w_cnt[k] = '0;
      end else if ((r_st[k] == DELAY && r_cnt[k] == L_DLY) || (r_st[k] == RPT && r_cnt[k] == L_PER)) begin
        w_st[k]  = RPT;
        w_cnt[k] = '0;
        w_rep[k] = 1'b1;
      end else if (r_st[k] != IDLE) begin
        w_cnt[k] = r_cnt[k] + CW'(1);
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_held  <= '0;
      r_press <= '0;
      r_rel   <= '0;
      r_rep   <= '0;
      r_roll  <= 1'b0;
      for (int k = 0; k < NKEY; k++) begin
        r_st[k]  <= IDLE;
        r_cnt[k] <= '0;
      end
    end else begin
      r_held  <= w_held_n;
      r_press <= w_press;
      r_rel   <= w_rel;
      r_rep   <= w_rep;
      r_roll  <= kc_valid & w_roll;
      r_st    <= w_st;
      r_cnt   <= w_cnt;
    end
  end
  assign key_held     = r_held;
  assign key_press    = r_press;
  assign key_release  = r_rel;
  assign key_repeat   = r_rep;
  assign any_held     = |r_held;
  assign rollover_err = r_roll;
endmodule
